// File: rtl/convolver_if.sv
// Memory-side bus of the convolver: image and filter read ports, the
// feature write port and the end-of-convolution flag.
//
// Read handshake (image and filter ports): the master raises EN for exactly
// one cycle with ADDRESS valid and then holds ADDRESS; the slave answers
// after any latency by raising DATA_VAL for one cycle with DIN valid.
// The master captures DIN on the rising edge where DATA_VAL=1. It keeps
// only one request outstanding per port, so EN is low on that edge. A
// DATA_VAL with no request outstanding carries no meaning and is dropped.
interface convolver_if #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 5
);
   logic                    IMAGE_RAM_EN;
   logic [ADDR_WIDTH-1:0]   IMAGE_RAM_ADDRESS;
   logic [WIDTH-1:0]        IMAGE_RAM_DIN;
   logic                    IMAGE_RAM_DATA_VAL;
   logic                    FILTER_RAM_EN;
   logic [ADDR_WIDTH-1:0]   FILTER_RAM_ADDRESS;
   logic [WIDTH-1:0]        FILTER_RAM_DIN;
   logic                    FILTER_RAM_DATA_VAL;
   logic                    FEATURE_RAM_EN;
   logic                    FEATURE_RAM_WEN;
   logic [ADDR_WIDTH-1:0]   FEATURE_RAM_ADDRESS;
   logic [2*WIDTH-1:0]      FEATURE_RAM_DOUT;
   logic [2*WIDTH-1:0]      FEATURE_RAM_DIN;
   logic                    FEATURE_RAM_DATA_VAL;
   logic                    eoc;

   modport master (
      output IMAGE_RAM_EN, IMAGE_RAM_ADDRESS,
      input  IMAGE_RAM_DIN, IMAGE_RAM_DATA_VAL,
      output FILTER_RAM_EN, FILTER_RAM_ADDRESS,
      input  FILTER_RAM_DIN, FILTER_RAM_DATA_VAL,
      output FEATURE_RAM_EN, FEATURE_RAM_WEN, FEATURE_RAM_ADDRESS, FEATURE_RAM_DOUT,
      input  FEATURE_RAM_DIN, FEATURE_RAM_DATA_VAL,
      output eoc
   );

   modport slave (
      input  IMAGE_RAM_EN, IMAGE_RAM_ADDRESS,
      output IMAGE_RAM_DIN, IMAGE_RAM_DATA_VAL,
      input  FILTER_RAM_EN, FILTER_RAM_ADDRESS,
      output FILTER_RAM_DIN, FILTER_RAM_DATA_VAL,
      input  FEATURE_RAM_EN, FEATURE_RAM_WEN, FEATURE_RAM_ADDRESS, FEATURE_RAM_DOUT,
      output FEATURE_RAM_DIN, FEATURE_RAM_DATA_VAL,
      input  eoc
   );
endinterface

// File: rtl/convolver.sv
// convolver: loads a KxK filter and an IMGxIMG map from external RAMs, then
// computes the valid-region 2-D convolution one MAC per cycle and writes
// each 16-bit result to the feature RAM. eoc stays high once all are written.
module convolver #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int IMG        = 5,
   parameter int K          = 3
) (
   input  logic         clk,
   input  logic         resetn,
   convolver_if.master  bus,
   output logic [2:0]   dbg_state
);
   localparam int OUT = IMG - K + 1;
   localparam int NW  = K * K;
   localparam int NI  = IMG * IMG;
   localparam int WAW = $clog2(NW);
   localparam int IAW = $clog2(NI);
   localparam int CW  = $clog2(IMG);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_LOAD_I, S_COMPUTE, S_WRITE, S_DONE
   } state_t;

   state_t state, state_nx;

   logic signed [WIDTH-1:0]   w_mem   [NW];
   logic signed [WIDTH-1:0]   img_mem [NI];
   logic [ADDR_WIDTH-1:0]     idx;        // fetch address during the load phases
   logic                      pending;    // a read request is outstanding
   logic [CW-1:0]             kr, kc, orow, ocol;
   logic [2*WIDTH-1:0]        acc;

   logic                      w_cap, i_cap, w_last, i_last, k_last, o_last, first_tap;
   logic [IAW-1:0]            pix_idx;
   logic [WAW-1:0]            tap_idx;
   logic signed [2*WIDTH-1:0] product;
   logic [ADDR_WIDTH-1:0]     out_addr;
   logic                      unused_feature_rd;

   // Feature RAM read data and its strobe carry nothing this block needs.
   assign unused_feature_rd = ^{bus.FEATURE_RAM_DIN, bus.FEATURE_RAM_DATA_VAL};

   assign w_cap     = (state == S_LOAD_W) && pending && bus.FILTER_RAM_DATA_VAL;
   assign i_cap     = (state == S_LOAD_I) && pending && bus.IMAGE_RAM_DATA_VAL;
   assign w_last    = (idx == ADDR_WIDTH'(NW - 1));
   assign i_last    = (idx == ADDR_WIDTH'(NI - 1));
   assign k_last    = (kr == CW'(K - 1)) && (kc == CW'(K - 1));
   assign o_last    = (orow == CW'(OUT - 1)) && (ocol == CW'(OUT - 1));
   assign first_tap = (kr == '0) && (kc == '0);
   assign pix_idx   = IAW'((orow + kr) * IMG + ocol + kc);
   assign tap_idx   = WAW'(kr * K + kc);
   assign product   = img_mem[pix_idx] * w_mem[tap_idx];
   assign out_addr  = ADDR_WIDTH'(orow * OUT + ocol);
   assign dbg_state = state;

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   // Next state and bus outputs; every output is zero unless its phase drives it.
   always_comb begin
      state_nx                = state;
      bus.IMAGE_RAM_EN        = 1'b0;
      bus.IMAGE_RAM_ADDRESS   = '0;
      bus.FILTER_RAM_EN       = 1'b0;
      bus.FILTER_RAM_ADDRESS  = '0;
      bus.FEATURE_RAM_EN      = 1'b0;
      bus.FEATURE_RAM_WEN     = 1'b0;
      bus.FEATURE_RAM_ADDRESS = '0;
      bus.FEATURE_RAM_DOUT    = '0;
      bus.eoc                 = 1'b0;
      case (state)
         S_IDLE: state_nx = S_LOAD_W;
         S_LOAD_W: begin
            bus.FILTER_RAM_EN      = !pending;
            bus.FILTER_RAM_ADDRESS = idx;
            if (w_cap && w_last) state_nx = S_LOAD_I;
         end
         S_LOAD_I: begin
            bus.IMAGE_RAM_EN      = !pending;
            bus.IMAGE_RAM_ADDRESS = idx;
            if (i_cap && i_last) state_nx = S_COMPUTE;
         end
         S_COMPUTE: begin
            if (k_last) state_nx = S_WRITE;
         end
         S_WRITE: begin
            bus.FEATURE_RAM_EN      = 1'b1;
            bus.FEATURE_RAM_WEN     = 1'b1;
            bus.FEATURE_RAM_ADDRESS = out_addr;
            bus.FEATURE_RAM_DOUT    = acc;
            state_nx = o_last ? S_DONE : S_COMPUTE;
         end
         S_DONE:  bus.eoc = 1'b1;
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath: fetch bookkeeping, register files, MAC and output position.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idx     <= '0;
         pending <= 1'b0;
         kr      <= '0;
         kc      <= '0;
         orow    <= '0;
         ocol    <= '0;
         acc     <= '0;
         for (int i = 0; i < NW; i++) w_mem[i] <= '0;
         for (int i = 0; i < NI; i++) img_mem[i] <= '0;
      end else begin
         case (state)
            S_LOAD_W: begin
               if (!pending) pending <= 1'b1;
               else if (w_cap) begin
                  w_mem[idx[WAW-1:0]] <= bus.FILTER_RAM_DIN;
                  pending <= 1'b0;
                  idx     <= w_last ? '0 : idx + 1'b1;
               end
            end
            S_LOAD_I: begin
               if (!pending) pending <= 1'b1;
               else if (i_cap) begin
                  img_mem[idx[IAW-1:0]] <= bus.IMAGE_RAM_DIN;
                  pending <= 1'b0;
                  idx     <= i_last ? '0 : idx + 1'b1;
               end
            end
            S_COMPUTE: begin
               // The first tap of each output restarts the sum; wraps mod 2^16.
               acc <= (first_tap ? '0 : acc) + product;
               if (kc == CW'(K - 1)) begin
                  kc <= '0;
                  kr <= (kr == CW'(K - 1)) ? '0 : kr + 1'b1;
               end else begin
                  kc <= kc + 1'b1;
               end
            end
            S_WRITE: begin
               if (ocol == CW'(OUT - 1)) begin
                  ocol <= '0;
                  orow <= orow + 1'b1;
               end else begin
                  ocol <= ocol + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_convolver.sv
// Bench for convolver: RAM models with 11-cycle read latency, a bus
// monitor, a table of directed and random cases against a reference model,
// and a mid-load reset sequence.
module tb_convolver;
   localparam int WIDTH = 8;
   localparam int AW    = 5;
   localparam int LAT   = 11;

   typedef logic [24:0][7:0] img_t;
   typedef logic [8:0][7:0]  w_t;
   typedef logic [8:0][15:0] res_t;
   typedef struct {
      string name;
      img_t  img;
      w_t    w;
      res_t  exp;
      bit    stray;
   } vec_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [2:0] dbg_state;
   int         n_tests = 0;
   int         n_fail  = 0;

   img_t img_data;
   w_t   w_data;
   bit   stray_en = 1'b0;

   always #5 clk = ~clk;

   convolver_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

   convolver dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Image RAM model: answers each request LAT edges later, may emit stray strobes when idle.
   int              i_cnt;
   logic [AW-1:0]   i_addr;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         i_cnt <= 0;
         bus.IMAGE_RAM_DATA_VAL <= 1'b0;
         bus.IMAGE_RAM_DIN <= '0;
      end else if (i_cnt != 0) begin
         i_cnt <= i_cnt - 1;
         bus.IMAGE_RAM_DATA_VAL <= (i_cnt == 1);
         if (i_cnt == 1) bus.IMAGE_RAM_DIN <= img_data[i_addr];
      end else if (bus.IMAGE_RAM_EN) begin
         i_cnt  <= LAT - 1;
         i_addr <= bus.IMAGE_RAM_ADDRESS;
         bus.IMAGE_RAM_DATA_VAL <= 1'b0;
      end else begin
         bus.IMAGE_RAM_DATA_VAL <= stray_en && ($urandom_range(0, 7) == 0);
         bus.IMAGE_RAM_DIN <= 8'($urandom);
      end
   end

   // Filter RAM model, same timing as the image RAM.
   int              f_cnt;
   logic [AW-1:0]   f_addr;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         f_cnt <= 0;
         bus.FILTER_RAM_DATA_VAL <= 1'b0;
         bus.FILTER_RAM_DIN <= '0;
      end else if (f_cnt != 0) begin
         f_cnt <= f_cnt - 1;
         bus.FILTER_RAM_DATA_VAL <= (f_cnt == 1);
         if (f_cnt == 1) bus.FILTER_RAM_DIN <= w_data[f_addr];
      end else if (bus.FILTER_RAM_EN) begin
         f_cnt  <= LAT - 1;
         f_addr <= bus.FILTER_RAM_ADDRESS;
         bus.FILTER_RAM_DATA_VAL <= 1'b0;
      end else begin
         bus.FILTER_RAM_DATA_VAL <= stray_en && ($urandom_range(0, 7) == 0);
         bus.FILTER_RAM_DIN <= 8'($urandom);
      end
   end

   // Feature RAM model: strobes DATA_VAL with junk the cycle after any access.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.FEATURE_RAM_DATA_VAL <= 1'b0;
         bus.FEATURE_RAM_DIN <= '0;
      end else begin
         bus.FEATURE_RAM_DATA_VAL <= bus.FEATURE_RAM_EN;
         bus.FEATURE_RAM_DIN <= 16'($urandom);
      end
   end

   // Bus monitor, sampled mid-cycle: request counts, protocol errors, written results.
   int   f_req, i_req, wr_cnt, prot_err;
   bit   f_out, i_out, last_wr, eoc_prev;
   logic [AW-1:0] f_hold, i_hold;
   logic [15:0]   feat [9];
   always @(negedge clk) begin
      if (!resetn) begin
         f_req = 0; i_req = 0; wr_cnt = 0; prot_err = 0;
         f_out = 0; i_out = 0; last_wr = 0; eoc_prev = 0;
         for (int i = 0; i < 9; i++) feat[i] = 16'hBEEF;
      end else begin
         if (f_out && (bus.FILTER_RAM_EN || bus.FILTER_RAM_ADDRESS != f_hold)) prot_err++;
         if (f_out && bus.FILTER_RAM_DATA_VAL) f_out = 0;
         else if (bus.FILTER_RAM_EN) begin
            if (int'(bus.FILTER_RAM_ADDRESS) != f_req) prot_err++;
            f_hold = bus.FILTER_RAM_ADDRESS;
            f_req++;
            f_out = 1;
         end
         if (i_out && (bus.IMAGE_RAM_EN || bus.IMAGE_RAM_ADDRESS != i_hold)) prot_err++;
         if (i_out && bus.IMAGE_RAM_DATA_VAL) i_out = 0;
         else if (bus.IMAGE_RAM_EN) begin
            if (int'(bus.IMAGE_RAM_ADDRESS) != i_req) prot_err++;
            i_hold = bus.IMAGE_RAM_ADDRESS;
            i_req++;
            i_out = 1;
         end
         if (bus.FEATURE_RAM_EN != bus.FEATURE_RAM_WEN) prot_err++;
         if (bus.eoc && (bus.FILTER_RAM_EN || bus.IMAGE_RAM_EN || bus.FEATURE_RAM_EN)) prot_err++;
         if (bus.eoc !== (eoc_prev || last_wr)) prot_err++;
         eoc_prev = bus.eoc;
         last_wr  = 0;
         if (bus.FEATURE_RAM_EN && bus.FEATURE_RAM_WEN) begin
            if (int'(bus.FEATURE_RAM_ADDRESS) != wr_cnt || wr_cnt >= 9) prot_err++;
            else feat[wr_cnt] = bus.FEATURE_RAM_DOUT;
            last_wr = (wr_cnt == 8);
            wr_cnt++;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outputs();
      return {28'd0, bus.IMAGE_RAM_EN, bus.IMAGE_RAM_ADDRESS, bus.FILTER_RAM_EN,
              bus.FILTER_RAM_ADDRESS, bus.FEATURE_RAM_EN, bus.FEATURE_RAM_WEN,
              bus.FEATURE_RAM_ADDRESS, bus.FEATURE_RAM_DOUT, bus.eoc};
   endfunction

   // Reference: direct valid-region convolution, signed products, sum mod 2^16.
   function automatic res_t ref_conv(input img_t img, input w_t w);
      res_t r;
      for (int orow = 0; orow < 3; orow++)
         for (int ocol = 0; ocol < 3; ocol++) begin
            int s = 0;
            for (int kr = 0; kr < 3; kr++)
               for (int kc = 0; kc < 3; kc++)
                  s += int'($signed(img[(orow + kr) * 5 + ocol + kc])) * int'($signed(w[kr * 3 + kc]));
            r[orow * 3 + ocol] = 16'(s);
         end
      return r;
   endfunction

   // One full run: reset, start, wait for eoc, then compare results and bus accounting.
   task automatic run_one(input vec_t v);
      int cyc;
      resetn   = 1'b0;
      img_data = v.img;
      w_data   = v.w;
      stray_en = v.stray;
      repeat (3) @(negedge clk);
      check({v.name, ".rst_out"}, all_outputs(), 64'd0);
      resetn = 1'b1;
      cyc = 0;
      while (bus.FILTER_RAM_EN !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
      check({v.name, ".first_waddr"}, {59'd0, bus.FILTER_RAM_EN, bus.FILTER_RAM_ADDRESS}, 64'h20);
      cyc = 0;
      while (bus.eoc !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
      check({v.name, ".eoc"}, 64'(bus.eoc), 64'd1);
      repeat (20) @(negedge clk);
      for (int i = 0; i < 9; i++)
         check($sformatf("%s.out%0d", v.name, i), 64'(feat[i]), 64'(v.exp[i]));
      check({v.name, ".f_req"}, 64'(f_req), 64'd9);
      check({v.name, ".i_req"}, 64'(i_req), 64'd25);
      check({v.name, ".writes"}, 64'(wr_cnt), 64'd9);
      check({v.name, ".protocol"}, 64'(prot_err), 64'd0);
      check({v.name, ".eoc_hold"}, 64'(bus.eoc), 64'd1);
   endtask

   vec_t vecs[$];

   initial begin
      vec_t v;
      v.stray = 1'b0;
      v.name = "ones";
      for (int i = 0; i < 25; i++) v.img[i] = 8'd1;
      for (int i = 0; i < 9; i++) begin v.w[i] = 8'd1; v.exp[i] = 16'd9; end
      vecs.push_back(v);
      v.name = "center";
      for (int i = 0; i < 25; i++) v.img[i] = 8'(i);
      for (int i = 0; i < 9; i++) v.w[i] = (i == 4) ? 8'd1 : 8'd0;
      v.exp = {16'd18, 16'd17, 16'd16, 16'd13, 16'd12, 16'd11, 16'd8, 16'd7, 16'd6};
      vecs.push_back(v);
      v.stray = 1'b1;
      v.name = "neg";
      for (int i = 0; i < 25; i++) v.img[i] = 8'd2;
      for (int i = 0; i < 9; i++) begin v.w[i] = 8'hFF; v.exp[i] = 16'hFFEE; end
      vecs.push_back(v);
      v.name = "wrap";
      for (int i = 0; i < 25; i++) v.img[i] = 8'd127;
      for (int i = 0; i < 9; i++) begin v.w[i] = 8'd127; v.exp[i] = 16'h3709; end
      vecs.push_back(v);
      for (int n = 0; n < 3; n++) begin
         v.name = $sformatf("rand%0d", n);
         for (int i = 0; i < 25; i++) v.img[i] = 8'($urandom);
         for (int i = 0; i < 9; i++) v.w[i] = 8'($urandom);
         v.exp = ref_conv(v.img, v.w);
         vecs.push_back(v);
      end

      foreach (vecs[n]) run_one(vecs[n]);

      // Reset in the middle of the image load, then a clean run must follow.
      begin
         int cyc;
         resetn   = 1'b0;
         img_data = vecs[3].img;
         w_data   = vecs[3].w;
         stray_en = 1'b0;
         repeat (3) @(negedge clk);
         resetn = 1'b1;
         cyc = 0;
         while (i_req < 5 && cyc < 2000) begin @(negedge clk); cyc++; end
         check("midrst.reach_load_i", 64'(i_req >= 5), 64'd1);
         #2 resetn = 1'b0;
         #1 check("midrst.out_zero", all_outputs(), 64'd0);
         run_one(vecs[0]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
